// File: rtl/overlay_seq_pkg.sv
// Shared definitions for the overlay show sequencer.
// Holds the show state encodings, the layer enable bit positions, the text
// shadow maximum and small helpers for state decoding.
package overlay_seq_pkg;

  typedef enum logic [2:0] {
    ST_SINE  = 3'd0,
    ST_TEXT1 = 3'd1,
    ST_TEXT2 = 3'd2,
    ST_TEXT3 = 3'd3,
    ST_HOLD  = 3'd4,
    ST_BLANK = 3'd5,
    ST_ILL6  = 3'd6,
    ST_ILL7  = 3'd7
  } state_e;

  // layer_en bit positions
  localparam int LYR_DEMO = 0;
  localparam int LYR_TT08 = 1;
  localparam int LYR_SDA  = 2;
  localparam int LYR_SINE = 3;

  localparam logic [2:0] SHADOW_MAX = 3'd4;

  function automatic logic [3:0] layers_of(state_e s);
    logic [3:0] l;
    l = '0;
    case (s)
      ST_SINE:  l[LYR_SINE] = 1'b1;
      ST_TEXT1: begin l[LYR_SINE] = 1'b1; l[LYR_DEMO] = 1'b1; end
      ST_TEXT2: begin l[LYR_SINE] = 1'b1; l[LYR_DEMO] = 1'b1; l[LYR_TT08] = 1'b1; end
      ST_TEXT3,
      ST_HOLD:  l = 4'b1111;
      default:  l = '0;
    endcase
    return l;
  endfunction

  function automatic state_e next_of(state_e s);
    case (s)
      ST_SINE:  return ST_TEXT1;
      ST_TEXT1: return ST_TEXT2;
      ST_TEXT2: return ST_TEXT3;
      ST_TEXT3: return ST_HOLD;
      ST_HOLD:  return ST_BLANK;
      default:  return ST_SINE;
    endcase
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Frame boundary detector.
// detect_o     : combinational, high while the pixel counters sit at
//                (x=0, y=V_ACTIVE); the sequencer samples it on the same edge.
// frame_tick_o : registered copy of detect_o, a one-cycle pulse aligned with
//                the sequencer's registered outputs.
// Ports: clk, rst (async high), x_i/y_i pixel counters.
module frame_tick_gen #(
  parameter int V_ACTIVE = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] x_i,
  input  logic [9:0] y_i,
  output logic       detect_o,
  output logic       frame_tick_o
);

  logic tick_q;

  assign detect_o = (x_i == 10'd0) && (y_i == 10'(V_ACTIVE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick_q <= 1'b0;
    else     tick_q <= detect_o;
  end

  assign frame_tick_o = tick_q;

endmodule

// File: rtl/overlay_sequencer.sv
// Frame-level show scheduler for the VGA overlay datapath.
// Steps SINE->TEXT1->TEXT2->TEXT3->HOLD->BLANK on frame boundaries and drives
// layer enables, sine phase offset and text shadow offset. Every output is a
// register updated only on the frame edge, so nothing changes mid-frame.
// Ports:
//   clk, rst     pixel clock, async active-high reset
//   x, y         pixel counters
//   run          1 advances the show, 0 freezes it (frame_tick still pulses)
//   skip         one-cycle request to leave the current state early
//   layer_en     [0]=DEMOSIINE [1]=TT08 [2]=SDA [3]=sine
//   sine_phase   sine x offset, shadow_off text shadow (0..4)
//   state        current state code, frame_tick boundary pulse
module overlay_sequencer
  import overlay_seq_pkg::*;
#(
  parameter int V_ACTIVE     = 480,
  parameter int SINE_FRAMES  = 120,
  parameter int TEXT_FRAMES  = 60,
  parameter int HOLD_FRAMES  = 240,
  parameter int BLANK_FRAMES = 30,
  parameter int SINE_STEP    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       run,
  input  logic       skip,
  output logic [3:0] layer_en,
  output logic [9:0] sine_phase,
  output logic [2:0] shadow_off,
  output logic [2:0] state,
  output logic       frame_tick
);

  logic       detect;

  state_e     state_q, state_d;
  logic [8:0] cnt_q, cnt_d;
  logic       pend_q, pend_d;
  logic [9:0] phase_q, phase_d;
  logic [2:0] shadow_q, shadow_d;
  logic       dn_q, dn_d;        // shadow direction, 1 = counting down
  logic [1:0] pre_q, pre_d;      // HOLD tick prescaler
  logic [3:0] layer_q, layer_d;

  logic [8:0] last_cnt;
  logic       advance;

  frame_tick_gen #(.V_ACTIVE(V_ACTIVE)) u_tick (
    .clk          (clk),
    .rst          (rst),
    .x_i          (x),
    .y_i          (y),
    .detect_o     (detect),
    .frame_tick_o (frame_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_SINE;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      phase_q  <= '0;
      shadow_q <= SHADOW_MAX;
      dn_q     <= 1'b1;
      pre_q    <= '0;
      layer_q  <= 4'b1000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      phase_q  <= phase_d;
      shadow_q <= shadow_d;
      dn_q     <= dn_d;
      pre_q    <= pre_d;
      layer_q  <= layer_d;
    end
  end

  // Last dwell count for the current state (DUR-1).
  always_comb begin
    last_cnt = '0;
    case (state_q)
      ST_SINE:  last_cnt = 9'(SINE_FRAMES - 1);
      ST_TEXT1,
      ST_TEXT2,
      ST_TEXT3: last_cnt = 9'(TEXT_FRAMES - 1);
      ST_HOLD:  last_cnt = 9'(HOLD_FRAMES - 1);
      ST_BLANK: last_cnt = 9'(BLANK_FRAMES - 1);
      default:  last_cnt = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q | skip;
    phase_d  = phase_q;
    shadow_d = shadow_q;
    dn_d     = dn_q;
    pre_d    = pre_q;
    // skip on the tick cycle itself counts, and folds with natural expiry
    advance  = pend_q | skip | (cnt_q == last_cnt);

    if (detect) begin
      if (state_q == ST_ILL6 || state_q == ST_ILL7) begin
        // recovery ignores run
        state_d  = ST_SINE;
        cnt_d    = '0;
        shadow_d = SHADOW_MAX;
        dn_d     = 1'b1;
        pre_d    = '0;
      end else if (run) begin
        pend_d = 1'b0;
        if (state_q != ST_BLANK) phase_d = phase_q + 10'(SINE_STEP);
        if (advance) begin
          state_d  = next_of(state_q);
          cnt_d    = '0;
          // both entering and leaving HOLD start from the top of the triangle
          shadow_d = SHADOW_MAX;
          dn_d     = 1'b1;
          pre_d    = '0;
        end else begin
          cnt_d = cnt_q + 9'd1;
          if (state_q == ST_HOLD) begin
            pre_d = pre_q + 2'd1;
            if (pre_q == 2'd3) begin
              // reverse when stepping off either end: 4,3,2,1,0,1,...,4,3
              if (dn_q) begin
                if (shadow_q == 3'd0) begin shadow_d = 3'd1; dn_d = 1'b0; end
                else                        shadow_d = shadow_q - 3'd1;
              end else begin
                if (shadow_q == SHADOW_MAX) begin shadow_d = SHADOW_MAX - 3'd1; dn_d = 1'b1; end
                else                              shadow_d = shadow_q + 3'd1;
              end
            end
          end
        end
      end
    end

    layer_d = layers_of(state_d);
  end

  assign layer_en   = layer_q;
  assign sine_phase = phase_q;
  assign shadow_off = shadow_q;
  assign state      = state_q;

endmodule

// File: doc/overlay_sequencer.md
# overlay_sequencer

Frame-level scheduler for the VGA overlay datapath. It detects each frame boundary from the pixel counters and steps a show state machine. Per frame it drives the layer enables (sine, DEMOSIINE, TT08, SDA text), the sine-wave phase offset and the text shadow offset. All outputs change only at the frame boundary, so the overlay never tears mid-frame.

## Interface
- `V_ACTIVE`, 480: first non-visible line; the frame boundary is pixel (x=0, y=V_ACTIVE).
- `SINE_FRAMES`, 120: frames spent in SINE (1..512).
- `TEXT_FRAMES`, 60: frames spent in each of TEXT1/TEXT2/TEXT3 (1..512).
- `HOLD_FRAMES`, 240: frames spent in HOLD (1..512).
- `BLANK_FRAMES`, 30: frames spent in BLANK (1..512).
- `SINE_STEP`, 2: phase increment per running frame (0..1023).

Ports:
- `clk` in 1: pixel clock, the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `x` in 10: current pixel column.
- `y` in 10: current pixel row.
- `run` in 1: 1 advances the show; 0 freezes it.
- `skip` in 1: single-cycle request to leave the current state at the next running frame boundary.
- `layer_en` out 4: layer enables. [0]=DEMOSIINE, [1]=TT08, [2]=SDA, [3]=sine.
- `sine_phase` out 10: x offset applied to the sine layers.
- `shadow_off` out 3: text shadow displacement (0..4).
- `state` out 3: current state code.
- `frame_tick` out 1: one-cycle pulse at each frame boundary.

## Operation
- Boundary detection: `detect = (x==0 && y==V_ACTIVE)`, combinational. The rising edge on which `detect` is sampled high is the frame edge.
- A frame edge is a running tick when `run=1`.
- States and codes, with `layer_en` in each:
  - SINE (0): 4'b1000
  - TEXT1 (1): 4'b1001
  - TEXT2 (2): 4'b1011
  - TEXT3 (3): 4'b1111
  - HOLD (4): 4'b1111
  - BLANK (5): 4'b0000
- Sequence: SINE → TEXT1 → TEXT2 → TEXT3 → HOLD → BLANK → SINE. Codes 6/7 are illegal and go to SINE at the next frame edge regardless of `run`.
- Dwell counter: 9-bit `frame_cnt`, incremented on each running tick.
  - When `frame_cnt == DUR-1` for the current state, the tick transitions to the next state and clears the counter.
  - DUR=1 therefore transitions on every running tick.
- Skip: `skip_pending` sets when `skip=1`.
  - At the next running tick it forces the transition, clears `frame_cnt` and clears itself.
  - `skip` together with natural expiry on the same tick gives a single advance, not two.
  - A `skip` arriving in the same cycle as a running tick is consumed by that tick.
  - While `run=0`, `skip_pending` stays latched.
- Phase: on each running tick in any state except BLANK, `sine_phase <= sine_phase + SINE_STEP`, modulo 1024. The phase is frozen in BLANK and while `run=0`.
- Shadow offset:
  - Outside HOLD, `shadow_off = 4`.
  - In HOLD, a 2-bit prescaler counts running ticks. Every 4th tick `shadow_off` steps one position in a triangle 4,3,2,1,0,1,2,3,4,…
  - Direction reverses at 0 and at 4.
  - Entering HOLD loads `shadow_off=4`, direction down, prescaler 0. Leaving HOLD restores 4.
- `run=0`: `frame_tick` still pulses; state, counters, phase and shadow are frozen.

## Timing
- All outputs are registered.
- On the frame edge, `frame_tick` goes to 1 and the new state, `layer_en`, `sine_phase` and `shadow_off` become visible together, one cycle after `detect` is high. `frame_tick` returns to 0 the following cycle.
- Outputs are constant for the rest of the frame.
- Reset values:
  - `state` = SINE, `layer_en` = 4'b1000
  - `sine_phase` = 0, `shadow_off` = 4
  - `frame_tick` = 0
  - `frame_cnt`, prescaler and `skip_pending` = 0; shadow direction down.
- Reset mid-frame forces these values immediately (asynchronous). The first tick after reset release follows the normal rules.

## Structure
- Shared package `overlay_seq_pkg`: state encodings (SINE..BLANK), layer bit indices, shadow maximum (4).
- Sub-module `frame_tick_gen`: boundary compare plus registered one-cycle pulse. The sequencer consumes the combinational `detect` to stay aligned with the registered `frame_tick`.
- The sequencer holds the FSM, dwell counter, skip latch, phase accumulator and shadow triangle.

## Test plan
- Reset, run=1, SINE_FRAMES=2, TEXT_FRAMES=1, HOLD_FRAMES=3, BLANK_FRAMES=1, drive full frames → state 0,0,1,2,3,4,4,4,5,0 on successive ticks; `layer_en` 8,8,9,B,F,F,F,F,0,8.
- SINE_STEP=1000, 3 running ticks in SINE → `sine_phase` 1000, 976, 952 (mod-1024 wrap).
- HOLD_FRAMES=40, observe `shadow_off` over HOLD → 4 for ticks 1-3, 3 at tick 4, reaches 0 at tick 16, back to 1 at tick 20; returns to 4 in BLANK.
- run=0 for 5 frames with `skip` pulsed mid-frame → `frame_tick` pulses 5 times, state/phase unchanged; first tick after run=1 advances exactly one state.
- `skip` asserted in the frame where `frame_cnt` = DUR-1 → exactly one transition.
- `rst` asserted mid-HOLD between ticks → outputs return to SINE/1000/0/4 immediately, without a clock edge.
